// File: rtl/freq_measure_mc.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : freq_measure_mc                                               |
// | Purpose  : Multi-channel reciprocal frequency meter with edge-aligned    |
// |            gate, no-edge timeout and saturating counters.                |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module freq_measure_mc #(
    parameter int SIG_CH      = 4,
    parameter int CNT_W       = 32,
    parameter int GATE_W      = 32,
    parameter int TMO_W       = 24,
    parameter int SYNC_STAGES = 2,
    localparam int CH_W       = (SIG_CH > 1) ? $clog2(SIG_CH) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [SIG_CH-1:0]    sig_i,
    input  logic [CH_W-1:0]      ch_sel_i,
    input  logic [GATE_W-1:0]    gate_len_i,
    input  logic                 start_i,
    output logic                 busy_o,
    output logic                 reg_wr_en_o,
    output logic [2*CNT_W-1:0]   reg_wr_data_o,
    output logic                 timeout_o,
    output logic                 overflow_o
);

    localparam int              CH_N     = 2 ** CH_W;
    localparam logic [CH_W:0]   c_sig_ch = SIG_CH[CH_W:0];

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARM  = 2'd1,
        S_GATE = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                 r_state;
    logic [CH_W-1:0]        r_ch;
    logic [GATE_W-1:0]      r_gate_len;
    logic [GATE_W-1:0]      r_gate;
    logic [CNT_W-1:0]       r_ref;
    logic [CNT_W-1:0]       r_sig;
    logic [TMO_W-1:0]       r_tmo;
    logic                   r_busy;
    logic                   r_wr_en;
    logic [2*CNT_W-1:0]     r_wr_data;
    logic                   r_timeout;
    logic                   r_overflow;

    logic [SIG_CH-1:0]      r_sync [SYNC_STAGES];
    logic [SIG_CH-1:0]      r_sync_d;
    logic                   r_edge;

    logic                   w_accept;
    logic [CH_W-1:0]        w_ch_in;
    logic [CH_W-1:0]        w_ch_nxt;
    logic [CH_N-1:0]        w_rise_ext;
    logic [CNT_W-1:0]       w_ref_nxt;
    logic [CNT_W-1:0]       w_sig_nxt;
    logic [GATE_W:0]        w_gate_sum;
    logic [GATE_W-1:0]      w_gate_nxt;
    logic                   w_gate_close;
    logic [TMO_W-1:0]       w_tmo_inc;
    logic                   w_tmo_fire;

    // Out-of-range channel selects fall back to channel 0.
    assign w_accept   = (r_state == S_IDLE) && start_i;
    assign w_ch_in    = ({1'b0, ch_sel_i} < c_sig_ch) ? ch_sel_i : '0;
    assign w_ch_nxt   = w_accept ? w_ch_in : r_ch;
    assign w_rise_ext = CH_N'(r_sync[SYNC_STAGES-1] & ~r_sync_d);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sync[i] <= '0;
            end
            r_sync_d <= '0;
            r_edge   <= 1'b0;
        end else begin
            r_sync[0] <= sig_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
            r_sync_d <= r_sync[SYNC_STAGES-1];
            r_edge   <= w_rise_ext[w_ch_nxt];
        end
    end

    assign w_ref_nxt  = (&r_ref) ? r_ref : r_ref + 1'b1;
    assign w_sig_nxt  = (r_edge && !(&r_sig)) ? r_sig + 1'b1 : r_sig;
    assign w_tmo_inc  = r_tmo + 1'b1;
    assign w_tmo_fire = &w_tmo_inc;

    // Gate closing runs on its own elapsed counter so that a saturated
    // ref_cnt cannot keep the gate open forever.
    assign w_gate_sum   = {1'b0, r_gate} + {{GATE_W{1'b0}}, 1'b1};
    assign w_gate_nxt   = (&r_gate) ? r_gate : w_gate_sum[GATE_W-1:0];
    assign w_gate_close = w_gate_sum >= {1'b0, r_gate_len};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= S_IDLE;
            r_ch       <= '0;
            r_gate_len <= '0;
            r_gate     <= '0;
            r_ref      <= '0;
            r_sig      <= '0;
            r_tmo      <= '0;
            r_busy     <= 1'b0;
            r_wr_en    <= 1'b0;
            r_wr_data  <= '0;
            r_timeout  <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_wr_en <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_ch       <= w_ch_in;
                        r_gate_len <= gate_len_i;
                        r_timeout  <= 1'b0;
                        r_overflow <= 1'b0;
                        r_tmo      <= '0;
                        r_ref      <= '0;
                        r_sig      <= '0;
                        r_gate     <= '0;
                        r_busy     <= 1'b1;
                        r_state    <= S_ARM;
                    end
                end
                S_ARM: begin
                    if (r_edge) begin
                        r_ref   <= '0;
                        r_sig   <= '0;
                        r_gate  <= '0;
                        r_tmo   <= '0;
                        r_state <= S_GATE;
                    end else if (w_tmo_fire) begin
                        r_tmo     <= w_tmo_inc;
                        r_timeout <= 1'b1;
                        r_wr_en   <= 1'b1;
                        r_wr_data <= '0;
                        r_state   <= S_DONE;
                    end else begin
                        r_tmo <= w_tmo_inc;
                    end
                end
                S_GATE: begin
                    r_ref  <= w_ref_nxt;
                    r_sig  <= w_sig_nxt;
                    r_gate <= w_gate_nxt;
                    if ((&r_ref) || (r_edge && (&r_sig))) begin
                        r_overflow <= 1'b1;
                    end
                    // An edge takes priority over a simultaneous timeout.
                    if (r_edge) begin
                        r_tmo <= '0;
                        if (w_gate_close) begin
                            r_wr_en   <= 1'b1;
                            r_wr_data <= {w_sig_nxt, w_ref_nxt};
                            r_state   <= S_DONE;
                        end
                    end else if (w_tmo_fire) begin
                        r_tmo     <= w_tmo_inc;
                        r_timeout <= 1'b1;
                        r_wr_en   <= 1'b1;
                        r_wr_data <= {w_sig_nxt, w_ref_nxt};
                        r_state   <= S_DONE;
                    end else begin
                        r_tmo <= w_tmo_inc;
                    end
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy_o        = r_busy;
    assign reg_wr_en_o   = r_wr_en;
    assign reg_wr_data_o = r_wr_data;
    assign timeout_o     = r_timeout;
    assign overflow_o    = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_freq_measure_mc.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_freq_measure_mc                                            |
// | Purpose  : Self-checking bench for freq_measure_mc (small counters).     |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tb_freq_measure_mc;

    // SIG_CH=5 gives a 3-bit select, so ch_sel=5 is a genuine out-of-range value.
    localparam int SIG_CH      = 5;
    localparam int CNT_W       = 8;
    localparam int GATE_W      = 12;
    localparam int TMO_W       = 8;
    localparam int SYNC_STAGES = 2;
    localparam int CH_W        = 3;
    localparam int CNT_MAX     = (1 << CNT_W) - 1;

    logic                clk = 1'b0;
    logic                rst_i = 1'b1;
    logic [SIG_CH-1:0]   sig_i = '0;
    logic [CH_W-1:0]     ch_sel_i = '0;
    logic [GATE_W-1:0]   gate_len_i = '0;
    logic                start_i = 1'b0;
    logic                busy_o;
    logic                reg_wr_en_o;
    logic [2*CNT_W-1:0]  reg_wr_data_o;
    logic                timeout_o;
    logic                overflow_o;

    freq_measure_mc #(
        .SIG_CH      (SIG_CH),
        .CNT_W       (CNT_W),
        .GATE_W      (GATE_W),
        .TMO_W       (TMO_W),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .sig_i         (sig_i),
        .ch_sel_i      (ch_sel_i),
        .gate_len_i    (gate_len_i),
        .start_i       (start_i),
        .busy_o        (busy_o),
        .reg_wr_en_o   (reg_wr_en_o),
        .reg_wr_data_o (reg_wr_data_o),
        .timeout_o     (timeout_o),
        .overflow_o    (overflow_o)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int n_exp    = 0;
    int n_pulses = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Square-wave sources: period per[c] cycles (0 = held low), rise at phase 0.
    int     per [SIG_CH];
    int     ph  [SIG_CH];
    longint cyc = 0;
    longint last_rise [SIG_CH];

    always begin
        @(posedge clk);
        cyc++;
        #3;
        for (int c = 0; c < SIG_CH; c++) begin
            if (per[c] < 2) begin
                sig_i[c] = 1'b0;
            end else begin
                ph[c] = (ph[c] + 1) % per[c];
                if (ph[c] == 0) last_rise[c] = cyc;
                sig_i[c] = (ph[c] < per[c] / 2);
            end
        end
    end

    always @(negedge clk) if (reg_wr_en_o) n_pulses++;

    initial begin
        #(10 * 60000);
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // Gate spans whole periods until elapsed >= gate_len, at least one period.
    task automatic model(input int p, input int g, output int s, output int r, output bit o);
        int     n;
        longint t;
        n = (g <= p) ? 1 : (g + p - 1) / p;
        t = longint'(n) * p;
        s = n;
        r = (t > CNT_MAX) ? CNT_MAX : int'(t);
        o = (t > CNT_MAX);
    endtask

    task automatic settle();
        repeat (70) @(negedge clk);
    endtask

    // Called at a negedge with the DUT idle; returns at the first idle negedge.
    task automatic run_meas(input string tag, input int sel, input int g,
                            input int exp_sig, input int exp_ref,
                            input bit exp_tmo, input bit exp_ovf,
                            input int eff_ch, input bit inject);
        int wait_n;
        bit got;
        ch_sel_i   = sel[CH_W-1:0];
        gate_len_i = g[GATE_W-1:0];
        start_i    = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        chk({tag, ".busy_on"}, busy_o, 1);
        chk({tag, ".tmo_clr"}, timeout_o, 0);
        chk({tag, ".ovf_clr"}, overflow_o, 0);
        got    = 1'b0;
        wait_n = 0;
        while (!got && wait_n < 3000) begin
            if (inject && (wait_n == 120 || wait_n == 150)) begin
                start_i    = 1'b1;
                ch_sel_i   = 3'd1;
                gate_len_i = 12'd1;
            end else begin
                start_i = 1'b0;
            end
            @(negedge clk);
            wait_n++;
            if (reg_wr_en_o) got = 1'b1;
        end
        start_i = 1'b0;
        chk({tag, ".done"}, got, 1);
        if (got) begin
            n_exp++;
            chk({tag, ".sig"}, reg_wr_data_o[2*CNT_W-1:CNT_W], exp_sig);
            chk({tag, ".ref"}, reg_wr_data_o[CNT_W-1:0], exp_ref);
            chk({tag, ".tmo"}, timeout_o, exp_tmo);
            chk({tag, ".ovf"}, overflow_o, exp_ovf);
            chk({tag, ".busy_done"}, busy_o, 1);
            if (exp_tmo)
                chk({tag, ".tmo_time"}, (wait_n >= 250 && wait_n <= 262), 1);
            else if (per[eff_ch] >= 5)
                chk({tag, ".latency"}, cyc - last_rise[eff_ch], SYNC_STAGES + 2);
            @(negedge clk);
            chk({tag, ".busy_off"}, busy_o, 0);
            chk({tag, ".pulse_1cyc"}, reg_wr_en_o, 0);
            chk({tag, ".hold"}, reg_wr_data_o, {exp_sig[CNT_W-1:0], exp_ref[CNT_W-1:0]});
        end
    endtask

    initial begin
        int  s, r, sel, g, eff;
        bit  o, seen;
        for (int c = 0; c < SIG_CH; c++) begin
            per[c] = 0;
            ph[c] = 0;
            last_rise[c] = 0;
        end
        repeat (3) @(negedge clk);
        chk("rst.busy", busy_o, 0);
        chk("rst.wr_en", reg_wr_en_o, 0);
        chk("rst.data", reg_wr_data_o, 0);
        chk("rst.tmo", timeout_o, 0);
        chk("rst.ovf", overflow_o, 0);
        rst_i = 1'b0;

        // Reset in the middle of a gate aborts silently.
        per[0] = 10;
        settle();
        ch_sel_i = 3'd0; gate_len_i = 12'd100; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        repeat (40) @(negedge clk);
        chk("midrst.busy_pre", busy_o, 1);
        rst_i = 1'b1;
        @(negedge clk);
        rst_i = 1'b0;
        chk("midrst.busy", busy_o, 0);
        chk("midrst.data", reg_wr_data_o, 0);
        chk("midrst.flags", {timeout_o, overflow_o, reg_wr_en_o}, 0);
        seen = 1'b0;
        repeat (150) begin
            @(negedge clk);
            if (reg_wr_en_o) seen = 1'b1;
        end
        chk("midrst.no_pulse", seen, 0);

        run_meas("basic", 0, 100, 10, 100, 0, 0, 0, 0);

        per[0] = 3; per[1] = 3; per[2] = 7; per[3] = 3; per[4] = 3;
        settle();
        run_meas("chsel", 2, 50, 8, 56, 0, 0, 2, 0);

        per[1] = 13;
        settle();
        run_meas("gate0", 1, 0, 1, 13, 0, 0, 1, 0);
        run_meas("gate1", 1, 1, 1, 13, 0, 0, 1, 0);

        per[0] = 11;
        settle();
        model(11, 60, s, r, o);
        run_meas("sel_oor", 5, 60, s, r, 0, o, 0, 0);

        per[3] = 0;
        settle();
        run_meas("tmo", 3, 100, 0, 0, 1, 0, 3, 0);
        model(11, 20, s, r, o);
        run_meas("after_tmo", 0, 20, s, r, 0, o, 0, 0);

        per[0] = 40;
        settle();
        run_meas("ovf", 0, 300, 8, 255, 0, 1, 0, 1);
        run_meas("b2b", 0, 30, 1, 40, 0, 0, 0, 0);

        for (int k = 0; k < 10; k++) begin
            for (int c = 0; c < SIG_CH; c++) per[c] = $urandom_range(2, 30);
            settle();
            sel = $urandom_range(0, 7);
            g   = $urandom_range(0, 200);
            eff = (sel < SIG_CH) ? sel : 0;
            model(per[eff], g, s, r, o);
            run_meas($sformatf("rnd%0d", k), sel, g, s, r, 0, o, eff, 0);
        end

        repeat (5) @(negedge clk);
        #1;
        chk("pulse_count", n_pulses, n_exp);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
